// File: rtl/rf_dump.sv
// Register-file dump engine: freezes the core, reads r0..r(NREGS-1) through one
// read port, and streams a framed byte sequence over a valid/ready interface.
module rf_dump #(
    parameter int         WIDTH     = 32,
    parameter int         ADDR_SIZE = 4,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [ADDR_SIZE-1:0] ra,
    input  logic [WIDTH-1:0]     rf_data,
    output logic                 hold,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_SIZE-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_IDX,
        S_DATA,
        S_FIN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_SIZE-1:0] idx;
    logic [ADDR_SIZE-1:0] ra_last;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     capture;
    logic                 handshake;
    logic                 last_byte;
    logic                 last_reg;

    assign handshake = tx_valid & tx_ready;
    assign last_byte = (cnt == CNT_LAST);
    assign last_reg  = (idx == IDX_LAST);
    assign hold      = busy;

    // The address only moves while reading; otherwise it parks on the last register read.
    assign ra = (state == S_RD) ? idx : ra_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            ra_last <= '0;
            cnt     <= '0;
            capture <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx <= '0;
                        cnt <= '0;
                    end
                end
                S_HDR: begin
                    if (handshake) begin
                        idx <= '0;
                    end
                end
                S_RD: begin
                    capture <= rf_data;
                    ra_last <= idx;
                end
                S_IDX: begin
                    if (handshake) begin
                        cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (handshake) begin
                        if (!last_byte) begin
                            cnt <= cnt + 1'b1;
                        end else if (!last_reg) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (handshake) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                busy       = 1'b1;
                state_next = S_IDX;
            end
            S_IDX: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'(idx);
                if (handshake) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = capture[8*cnt +: 8];
                if (handshake && last_byte) begin
                    state_next = last_reg ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Abort drops the partial frame without a done pulse.
        if (state != S_IDLE && abort) begin
            state_next = S_IDLE;
        end
    end

endmodule
